l2_noc2_arb: RTL
================

L2_NOC2_ARB -- requirements
Module: l2_noc2_arb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, meaning NoC flit width.
REQ-002 The block SHALL have parameter LEN_LSB, default 22, meaning the bit position of the 8-bit msg_length field in a header flit (bits [29:22]).
REQ-003 The block SHALL have parameter OBUF_DEPTH, default 2, meaning the output buffer entry count; allowed values are 2 or 4.
REQ-004 Port clk, input, 1, is the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1, is the reset; it is asynchronous and active-high.
REQ-006 Ports pipe1_valid, input, 1, and pipe1_data, input, DATA_W, form the pipe1 (request pipeline) NoC2 message flit stream.
REQ-007 Port pipe1_ready, output, 1, SHALL mean that a pipe1 flit is accepted this cycle when pipe1_valid is also high.
REQ-008 Ports pipe2_valid, input, 1, pipe2_data, input, DATA_W, and pipe2_ready, output, 1, form the pipe2 (response pipeline) flit stream, with the same rules as pipe1.
REQ-009 Ports noc2_valid_out, output, 1, noc2_data_out, output, DATA_W, and noc2_ready_out, input, 1, form the merged NoC2 output stream.
REQ-010 Port owner, output, 2, SHALL be a one-hot lock holder: bit0 = pipe1, bit1 = pipe2, 0 = unlocked.
REQ-011 Port busy, output, 1, SHALL be high when a lock is held or the output buffer is non-empty.

Function
REQ-012 A flit transfers on any interface when valid and ready are both high in the same cycle.
REQ-013 The FSM SHALL have two states: IDLE (no owner) and LOCKED (owner set, remaining-flit counter rem > 0).
REQ-014 In IDLE, if exactly one pipe is valid and the buffer is not full, that pipe SHALL be granted its header that cycle.
REQ-015 In IDLE, if both pipes are valid, the grant SHALL go to the pipe not granted last; after reset, pipe2 wins the first tie.
REQ-016 When a header transfers with msg_length = L > 0, the FSM SHALL enter LOCKED, set owner to the granted pipe, and load rem = L.
REQ-017 When a header transfers with L = 0, the FSM SHALL remain in IDLE, and the next header may be granted the following cycle.
REQ-018 In LOCKED, only the owner's ready may be high; each owner transfer SHALL decrement rem, and the transfer that makes rem 0 SHALL return the FSM to IDLE.
REQ-019 pipeX_ready SHALL equal (pipe X is granted this cycle) AND (buffer not full); ready SHALL never depend on the same pipe's own valid except through arbitration.
REQ-020 Flits SHALL leave through a FIFO of OBUF_DEPTH entries; a flit accepted in cycle N SHALL be visible on noc2_data_out no earlier than cycle N+1.
REQ-021 An empty buffer SHALL deliver one flit per cycle with one-cycle latency; sustained throughput SHALL be 1 flit/cycle while noc2_ready_out is high.
REQ-022 When the buffer is full, it SHALL accept a new flit in the same cycle that it dequeues one.
REQ-023 noc2_valid_out SHALL be high exactly when the buffer is non-empty, and noc2_data_out SHALL remain stable while valid is high and ready is low.
REQ-024 Flits of different messages SHALL never interleave on the output, and flit order within each pipe SHALL be preserved.
REQ-025 The rem counter SHALL be 8 bits wide with no wrap; L = 255 SHALL be legal.

Reset
REQ-026 While rst is high, the following SHALL hold: FSM = IDLE, owner = 0, rem = 0, buffer empty, noc2_valid_out = 0, pipe1_ready = pipe2_ready = 0, busy = 0, and the last-grant pointer points at pipe1.
REQ-027 A reset asserted mid-message SHALL discard the partial message and buffered flits, with no output activity until after reset deasserts.
REQ-028 The first grant SHALL be possible in the first cycle after rst deasserts.

Structure
REQ-029 The header field offsets (msg_length position and width) and the owner encoding SHALL live in the shared L2 package, alongside the existing NoC header constants.
REQ-030 The output buffer SHALL be a sub-module l2_noc2_obuf (a synchronous FIFO with count, full and empty); the arbiter FSM SHALL stay in l2_noc2_arb.

Verification
REQ-031 Single message: pipe1 header with L=2 plus 2 payload flits, ready_out=1 -> the 3 flits appear on cycles 1-3 in order; owner=01 through the last payload, then 00.
REQ-032 Tie: both pipes present an L=1 message at the same time, just after reset -> pipe2's message is output first, then pipe1's, with no interleaving.
REQ-033 Backpressure: ready_out=0 for 5 cycles during a pipe1 L=3 message -> the buffer fills to 2, pipe1_ready drops, data stays stable, and no flit is lost or duplicated after release.
REQ-034 Zero-length: pipe2 sends back-to-back L=0 headers while pipe1 is valid -> the grants alternate pipe2, pipe1, pipe2.
REQ-035 Max length: pipe1 L=255 -> 256 flits leave with pipe2 starved until the last one, then pipe2 is granted on the next cycle.
REQ-036 Mid-message reset: assert rst after 2 of 4 flits -> outputs are reset immediately, and a new message after deassertion is delivered cleanly.

Source files
------------

// File: rtl/l2_noc2_arb_pkg.sv
// Shared L2 NoC2 constants: header field offsets, owner encoding and arbiter state type.
package l2_noc2_arb_pkg;

   // NoC header layout
   localparam int NOC2_MSG_TYPE_LSB = 14;
   localparam int NOC2_MSG_TYPE_W   = 8;
   localparam int NOC2_LEN_LSB      = 22;
   localparam int NOC2_LEN_W        = 8;

   typedef logic [NOC2_LEN_W-1:0] len_t;

   // One-hot lock holder encoding
   typedef logic [1:0] owner_t;
   localparam owner_t OWN_NONE = 2'b00;
   localparam owner_t OWN_P1   = 2'b01;
   localparam owner_t OWN_P2   = 2'b10;

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_LOCKED = 1'b1
   } arb_state_t;

endpackage

// File: rtl/l2_noc2_obuf.sv
// Synchronous output FIFO for the NoC2 merge; accepts a push while full if it pops in the same cycle.
module l2_noc2_obuf
   import l2_noc2_arb_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 2,
   parameter int PTR_W  = $clog2(DEPTH),
   parameter int CNT_W  = PTR_W + 1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty
);

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [CNT_W-1:0]  count_r;
   logic              do_pop_s;
   logic              do_push_s;

   assign empty     = (count_r == CNT_W'(0));
   assign full      = (count_r == CNT_W'(DEPTH));
   assign count     = count_r;
   assign pop_data  = mem_r[rd_ptr_r];
   assign do_pop_s  = pop & ~empty;
   assign do_push_s = push & (~full | do_pop_s);

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= PTR_W'(0);
         rd_ptr_r <= PTR_W'(0);
         count_r  <= CNT_W'(0);
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         count_r <= count_r + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
      end
   end

   // Storage array, no reset needed since occupancy gates visibility
   always_ff @(posedge clk) begin
      if (do_push_s) mem_r[wr_ptr_r] <= push_data;
   end

endmodule

// File: rtl/l2_noc2_arb.sv
// Merges pipe1/pipe2 NoC2 messages onto one output, locking to a pipe for a whole message.
module l2_noc2_arb
   import l2_noc2_arb_pkg::*;
#(
   parameter int DATA_W     = 64,
   parameter int LEN_LSB    = NOC2_LEN_LSB,
   parameter int OBUF_DEPTH = 2
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              pipe1_valid,
   input  logic [DATA_W-1:0] pipe1_data,
   output logic              pipe1_ready,
   input  logic              pipe2_valid,
   input  logic [DATA_W-1:0] pipe2_data,
   output logic              pipe2_ready,
   output logic              noc2_valid_out,
   output logic [DATA_W-1:0] noc2_data_out,
   input  logic              noc2_ready_out,
   output logic [1:0]        owner,
   output logic              busy
);

   localparam int CNT_W = $clog2(OBUF_DEPTH) + 1;

   arb_state_t        state_r;
   owner_t            owner_r;
   len_t              rem_r;
   logic              last_p2_r;
   logic              gnt1_s;
   logic              gnt2_s;
   logic              xfer1_s;
   logic              xfer2_s;
   logic              push_s;
   logic              pop_s;
   logic              space_s;
   logic [DATA_W-1:0] push_data_s;
   len_t              hdr_len_s;
   logic              fifo_full_s;
   logic              fifo_empty_s;
   logic [CNT_W-1:0]  fifo_count_s;

   // Grant selection: owner while locked, otherwise round-robin on ties
   always_comb begin
      gnt1_s = 1'b0;
      gnt2_s = 1'b0;
      if (state_r == S_LOCKED) begin
         gnt1_s = owner_r[0];
         gnt2_s = owner_r[1];
      end else if (pipe1_valid && pipe2_valid) begin
         gnt1_s = last_p2_r;
         gnt2_s = ~last_p2_r;
      end else begin
         gnt1_s = pipe1_valid;
         gnt2_s = pipe2_valid;
      end
   end

   // A full buffer still has room when it drains this cycle
   assign pop_s       = ~fifo_empty_s & noc2_ready_out;
   assign space_s     = ~fifo_full_s | pop_s;
   assign pipe1_ready = gnt1_s & space_s & ~rst;
   assign pipe2_ready = gnt2_s & space_s & ~rst;
   assign xfer1_s     = pipe1_valid & pipe1_ready;
   assign xfer2_s     = pipe2_valid & pipe2_ready;
   assign push_s      = xfer1_s | xfer2_s;
   assign push_data_s = xfer2_s ? pipe2_data : pipe1_data;
   assign hdr_len_s   = push_data_s[LEN_LSB +: NOC2_LEN_W];

   assign noc2_valid_out = ~fifo_empty_s;
   assign owner          = owner_r;
   assign busy           = (state_r == S_LOCKED) | (fifo_count_s != CNT_W'(0));

   // Message lock FSM with remaining-flit counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= S_IDLE;
         owner_r   <= OWN_NONE;
         rem_r     <= len_t'(0);
         last_p2_r <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (push_s) begin
                  last_p2_r <= xfer2_s;
                  if (hdr_len_s != len_t'(0)) begin
                     state_r <= S_LOCKED;
                     owner_r <= xfer2_s ? OWN_P2 : OWN_P1;
                     rem_r   <= hdr_len_s;
                  end
               end
            end
            S_LOCKED: begin
               if (push_s) begin
                  rem_r <= rem_r - len_t'(1);
                  if (rem_r == len_t'(1)) begin
                     state_r <= S_IDLE;
                     owner_r <= OWN_NONE;
                  end
               end
            end
            default: begin
               state_r <= S_IDLE;
               owner_r <= OWN_NONE;
               rem_r   <= len_t'(0);
            end
         endcase
      end
   end

   l2_noc2_obuf #(
      .DATA_W (DATA_W),
      .DEPTH  (OBUF_DEPTH)
   ) u_obuf (
      .clk       (clk),
      .rst       (rst),
      .push      (push_s),
      .push_data (push_data_s),
      .pop       (pop_s),
      .pop_data  (noc2_data_out),
      .count     (fifo_count_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s)
   );

endmodule
